// File: rtl/fp_normalize.sv
// Post-add normalizer: CARRY right shift, LEFT shift by lz count, ZERO, and UNDER flush/denormal (FP_NORM_DENORM_EN).
// Latency 2 cycles (S1 input/decode register, S2 shifted result register); one result per cycle when unstalled.
// Backpressure: each stage holds while the next is full and stalled; in_ready drops only when both stages are full.
module fp_normalize #(
    parameter int EW  = 8,
    parameter int MW  = 24,
    parameter int LZW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [MW:0]   in_mant,
    input  logic [LZW-1:0] in_lz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [MW-1:0] out_mant,
    output logic          out_guard,
    output logic          out_zero,
    output logic          out_ovf,
    output logic          out_unf
);

    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [2:0] {
        K_LEFT,
        K_CARRY,
        K_OVF,
        K_ZERO,
        K_UNDER
    } kind_t;

    logic          s1_valid;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [MW:0]   s1_mant;
    logic [LZW-1:0] s1_lz;
    kind_t         s1_kind;
    logic          s2_valid;
    logic          s2_adv;

    logic [EW-1:0] in_lz_ext;
    logic [EW-1:0] s1_lz_ext;
    kind_t         in_kind;

    assign s2_adv    = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_adv;
    assign out_valid = s2_valid;

    assign in_lz_ext = {{(EW-LZW){1'b0}}, in_lz};
    assign s1_lz_ext = {{(EW-LZW){1'b0}}, s1_lz};

    // Carry with exponent FE reaches all-ones; FF is folded in so the exponent never wraps.
    always_comb begin
        in_kind = K_LEFT;
        if (in_mant[MW])
            in_kind = (&in_exp[EW-1:1]) ? K_OVF : K_CARRY;
        else if (in_mant == '0)
            in_kind = K_ZERO;
        else if (in_exp <= in_lz_ext)
            in_kind = K_UNDER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
            s1_kind  <= K_LEFT;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_lz   <= in_lz;
                s1_kind <= in_kind;
            end
        end
    end

`ifdef FP_NORM_DENORM_EN
    logic [EW-1:0] den_sh;
    assign den_sh = (s1_exp == '0) ? '0 : s1_exp - EXP_ONE;
`endif

    logic [MW-1:0] n_mant;
    logic [EW-1:0] n_exp;
    logic          n_guard;
    logic          n_zero;
    logic          n_ovf;
    logic          n_unf;

    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_guard = 1'b0;
        n_zero  = 1'b0;
        n_ovf   = 1'b0;
        n_unf   = 1'b0;
        case (s1_kind)
            K_CARRY: begin
                n_mant  = s1_mant[MW:1];
                n_guard = s1_mant[0];
                n_exp   = s1_exp + EXP_ONE;
            end
            K_OVF: begin
                n_exp = '1;
                n_ovf = 1'b1;
            end
            K_ZERO: n_zero = 1'b1;
            K_LEFT: begin
                n_mant = s1_mant[MW-1:0] << s1_lz;
                n_exp  = s1_exp - s1_lz_ext;
            end
            K_UNDER: begin
                n_unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
                n_mant = s1_mant[MW-1:0] << den_sh;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_guard <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_exp   <= n_exp;
                out_mant  <= n_mant;
                out_guard <= n_guard;
                out_zero  <= n_zero;
                out_ovf   <= n_ovf;
                out_unf   <= n_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed corner vectors, backpressure, mid-stream reset, random traffic vs reference model.
// Build with +define+FP_NORM_DENORM_EN to exercise the denormal variant.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic [4:0]  in_lz = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_guard, out_zero, out_ovf, out_unf;

    always #5 clk = ~clk;

    fp_normalize #(.EW(8), .MW(24), .LZW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_lz(in_lz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_guard(out_guard), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    // {sign, exp, mant, guard, zero, ovf, unf}
    logic [36:0] outvec;
    assign outvec = {out_sign, out_exp, out_mant, out_guard, out_zero, out_ovf, out_unf};

    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb[$];
    logic        acc = 1'b0;
    logic        stall_prev = 1'b0;
    logic [36:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] lzc(input logic [24:0] m);
        int n = 0;
        for (int b = 23; b >= 0; b--) begin
            if (m[b]) return 5'(n);
            n++;
        end
        return 5'(n);
    endfunction

    // Reference: value-level arithmetic on exponent and magnitude.
    function automatic logic [36:0] model(input logic s, input logic [7:0] e,
                                          input logic [24:0] m, input logic [4:0] lz);
        int     ei = int'(e);
        int     li = int'(lz);
        longint mv = longint'(m);
        longint mm;
        logic [7:0]  xe = '0;
        logic [23:0] xm = '0;
        logic g = 1'b0, z = 1'b0, o = 1'b0, u = 1'b0;
        if (mv >= 64'd16777216) begin
            if (ei + 1 >= 255) begin
                xe = 8'hFF;
                o  = 1'b1;
            end else begin
                xe = 8'(ei + 1);
                xm = 24'(mv / 2);
                g  = (mv % 2) != 0;
            end
        end else if (mv == 0) begin
            z = 1'b1;
        end else if (ei > li) begin
            mm = (mv * (longint'(1) << li)) % (longint'(1) << 24);
            xm = 24'(mm);
            xe = 8'(ei - li);
        end else begin
            u = 1'b1;
`ifdef FP_NORM_DENORM_EN
            mm = (mv * (longint'(1) << ((ei == 0) ? 0 : ei - 1))) % (longint'(1) << 24);
            xm = 24'(mm);
`endif
        end
        return {s, xe, xm, g, z, o, u};
    endfunction

    // One clock: sample at negedge, score transfers, then return at posedge+1 for driving.
    task automatic step();
        @(negedge clk);
        acc = in_valid & in_ready;
        if (stall_prev) chk("hold_stable", 64'(outvec), 64'(held));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else chk("scoreboard", 64'(outvec), 64'(sb.pop_front()));
            chk("flag_excl", 64'($countones(outvec[2:0]) <= 1), 64'd1);
        end
        if (acc) sb.push_back(model(in_sign, in_exp, in_mant, in_lz));
        stall_prev = out_valid & ~out_ready;
        held = outvec;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_lz    = (m == 0) ? 5'($urandom_range(0, 31)) : lzc(m);
    endtask

    task automatic push_in(input logic s, input logic [7:0] e, input logic [24:0] m);
        drive(s, e, m);
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) step();
        step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e,
                            input logic [24:0] m, input logic [4:0] lz, input logic [36:0] expv);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_lz     = lz;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(outvec), 64'(expv));
        step();
    endtask

    task automatic rand_input();
        logic [7:0]  e;
        logic [24:0] m;
        int k = $urandom_range(0, 9);
        e = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(0, 26)) : 8'($urandom_range(0, 254));
        if (k == 0) m = '0;
        else if (k <= 2) begin
            m = {1'b1, 24'($urandom)};
            if ($urandom_range(0, 3) == 0) e = 8'd254;
        end else begin
            m = 25'(($urandom & 32'hFFFFFF) >> $urandom_range(0, 23));
            if (m == 0) m = 25'd1;
        end
        drive(1'($urandom), e, m);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(outvec), 64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        directed("carry", 1'b0, 8'h7F, 25'h1000000, 5'd0, {1'b0, 8'h80, 24'h800000, 4'b0000});
        directed("left", 1'b0, 8'h80, 25'h0400000, 5'd1, {1'b0, 8'h7F, 24'h800000, 4'b0000});
        directed("ovf", 1'b0, 8'hFE, 25'h1000001, 5'd0, {1'b0, 8'hFF, 24'h000000, 4'b0010});
        directed("zero", 1'b1, 8'h55, 25'h0000000, 5'd13, {1'b1, 8'h00, 24'h000000, 4'b0100});
        directed("carry_guard", 1'b1, 8'h10, 25'h1800003, 5'd0, {1'b1, 8'h11, 24'hC00001, 4'b1000});
`ifdef FP_NORM_DENORM_EN
        directed("under", 1'b0, 8'h03, 25'h0040000, 5'd5, {1'b0, 8'h00, 24'h100000, 4'b0001});
`else
        directed("under", 1'b0, 8'h03, 25'h0040000, 5'd5, {1'b0, 8'h00, 24'h000000, 4'b0001});
`endif
        drain();

        // Backpressure: two accepts fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        drive(1'b0, 8'h40, 25'h0812345);
        step();
        chk("bp_acc0", 64'(acc), 64'd1);
        drive(1'b1, 8'h41, 25'h1ABCDEF);
        step();
        chk("bp_acc1", 64'(acc), 64'd1);
        drive(1'b0, 8'h02, 25'h0001234);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        chk("bp_no_acc", 64'(acc), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        push_in(1'b0, 8'h02, 25'h0001234);
        push_in(1'b1, 8'h00, 25'h0000000);
        drain();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rand_input();
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        drive(1'b0, 8'h20, 25'h0F00000);
        step();
        drive(1'b1, 8'h21, 25'h1F00001);
        step();
        in_valid = 1'b0;
        chk("rst_mid_full", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", 64'(outvec), 64'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
